// File: rtl/lut_func_eval.sv
// Reprogrammable N-input Boolean function unit: serial double-buffered truth table load,
// registered single-point evaluation and a full-table sweep that counts 1-minterms.
module lut_func_eval #(
   parameter int unsigned       N    = 4,
   parameter logic [2**N-1:0]   INIT = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_valid_i,
   input  logic         load_bit_i,
   output logic         load_ready_o,
   output logic         load_done_o,
   input  logic [N-1:0] x_i,
   input  logic         eval_valid_i,
   output logic         f_o,
   output logic         f_valid_o,
   input  logic         sweep_start_i,
   output logic         busy_o,
   output logic [N-1:0] sw_idx_o,
   output logic         sw_f_o,
   output logic         sw_valid_o,
   output logic         sw_last_o,
   output logic [N:0]   ones_count_o,
   output logic         sweep_done_o
);

   localparam int unsigned   Size   = 2**N;
   localparam logic [N-1:0]  IdxMax = N'(Size - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StSweep} state_e;

   state_e          state_q;
   logic [Size-1:0] active_q;
   logic [Size-1:0] shadow_q;
   logic [Size-1:0] shadow_wr;
   logic [N-1:0]    cnt_q;
   logic            load_ready_q;
   logic            load_done_q;
   logic            f_q;
   logic            f_valid_q;
   logic            busy_q;
   logic [N-1:0]    sw_idx_q;
   logic [N-1:0]    sw_idx_nxt;
   logic            sw_f_q;
   logic            sw_valid_q;
   logic            sw_last_q;
   logic [N:0]      ones_count_q;
   logic            sweep_done_q;
   logic            accept;

   assign accept     = load_valid_i && load_ready_q;
   assign sw_idx_nxt = sw_idx_q + N'(1);

   // Shadow image including the bit offered this cycle; committed whole on the last accept.
   always_comb begin
      shadow_wr        = shadow_q;
      shadow_wr[cnt_q] = load_bit_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         active_q     <= INIT;
         shadow_q     <= '0;
         cnt_q        <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         busy_q       <= 1'b0;
         sw_idx_q     <= '0;
         sw_f_q       <= 1'b0;
         sw_valid_q   <= 1'b0;
         sw_last_q    <= 1'b0;
         ones_count_q <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         load_done_q  <= 1'b0;
         sweep_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               busy_q <= 1'b0;
               if (accept) begin
                  shadow_q     <= shadow_wr;
                  cnt_q        <= cnt_q + N'(1);
                  state_q      <= StLoad;
                  load_ready_q <= 1'b1;
               end else if (sweep_start_i) begin
                  state_q      <= StSweep;
                  busy_q       <= 1'b1;
                  sw_valid_q   <= 1'b1;
                  sw_idx_q     <= '0;
                  sw_f_q       <= active_q[0];
                  sw_last_q    <= 1'b0;
                  ones_count_q <= '0;
                  load_ready_q <= 1'b0;
               end else begin
                  load_ready_q <= 1'b1;
               end
            end
            StLoad: begin
               if (accept) begin
                  shadow_q <= shadow_wr;
                  if (cnt_q == IdxMax) begin
                     active_q    <= shadow_wr;
                     cnt_q       <= '0;
                     state_q     <= StIdle;
                     load_done_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + N'(1);
                  end
               end
            end
            StSweep: begin
               ones_count_q <= ones_count_q + {{N{1'b0}}, sw_f_q};
               if (sw_last_q) begin
                  // busy stays high one more cycle, alongside sweep_done
                  state_q      <= StIdle;
                  sw_valid_q   <= 1'b0;
                  sw_last_q    <= 1'b0;
                  sweep_done_q <= 1'b1;
                  load_ready_q <= 1'b1;
               end else begin
                  sw_idx_q  <= sw_idx_nxt;
                  sw_f_q    <= active_q[sw_idx_nxt];
                  sw_last_q <= (sw_idx_nxt == IdxMax);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Eval reads the pre-commit table when it shares an edge with a commit.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         f_q       <= 1'b0;
         f_valid_q <= 1'b0;
      end else begin
         f_valid_q <= eval_valid_i;
         if (eval_valid_i) begin
            f_q <= active_q[x_i];
         end
      end
   end

   assign load_ready_o = load_ready_q;
   assign load_done_o  = load_done_q;
   assign f_o          = f_q;
   assign f_valid_o    = f_valid_q;
   assign busy_o       = busy_q;
   assign sw_idx_o     = sw_idx_q;
   assign sw_f_o       = sw_f_q;
   assign sw_valid_o   = sw_valid_q;
   assign sw_last_o    = sw_last_q;
   assign ones_count_o = ones_count_q;
   assign sweep_done_o = sweep_done_q;

endmodule

// File: tb/tb_lut_func_eval.sv
// Self-checking bench for lut_func_eval (N=4, INIT=0) against a truth-table reference model.
module tb_lut_func_eval;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       load_valid_i, load_bit_i, load_ready_o, load_done_o;
   logic [3:0] x_i;
   logic       eval_valid_i, f_o, f_valid_o;
   logic       sweep_start_i, busy_o;
   logic [3:0] sw_idx_o;
   logic       sw_f_o, sw_valid_o, sw_last_o;
   logic [4:0] ones_count_o;
   logic       sweep_done_o;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   logic [15:0] model_active;
   logic        exp_f;

   lut_func_eval #(.N(4), .INIT(16'h0000)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .load_valid_i (load_valid_i),
      .load_bit_i   (load_bit_i),
      .load_ready_o (load_ready_o),
      .load_done_o  (load_done_o),
      .x_i          (x_i),
      .eval_valid_i (eval_valid_i),
      .f_o          (f_o),
      .f_valid_o    (f_valid_o),
      .sweep_start_i(sweep_start_i),
      .busy_o       (busy_o),
      .sw_idx_o     (sw_idx_o),
      .sw_f_o       (sw_f_o),
      .sw_valid_o   (sw_valid_o),
      .sw_last_o    (sw_last_o),
      .ones_count_o (ones_count_o),
      .sweep_done_o (sweep_done_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      load_valid_i = 1'b0; load_bit_i = 1'b0; eval_valid_i = 1'b0;
      x_i = 4'h0; sweep_start_i = 1'b0;
      tick();
      check_eq("rst_outputs",
               {load_ready_o, load_done_o, f_o, f_valid_o, busy_o, sw_idx_o, sw_f_o,
                sw_valid_o, sw_last_o, ones_count_o, sweep_done_o}, 32'h0);
      model_active = 16'h0000;
      exp_f = 1'b0;
      rst_ni = 1'b1;
      tick();
      check_eq("rst_idle_ready", {load_ready_o, busy_o, sweep_done_o}, 32'b100);
   endtask

   // gaps: 0 none, 1 alternate cycles, 2 random; nbits < 16 leaves a partial load
   task automatic load_table(input logic [15:0] tbl, input int gaps, input bit with_sweep,
                             input int nbits);
      for (int i = 0; i < nbits; i++) begin
         load_valid_i  = 1'b1;
         load_bit_i    = tbl[i];
         eval_valid_i  = 1'b1;
         x_i           = 4'($urandom);
         sweep_start_i = (i == 0) ? with_sweep : 1'($urandom);
         tick();
         exp_f = model_active[x_i];
         check_eq("load_eval_f", f_o, exp_f);
         check_eq("load_done", load_done_o, (i == 15));
         check_eq("load_ready", load_ready_o, 1);
         check_eq("load_no_sweep", {busy_o, sw_valid_o}, 0);
         if (i != nbits - 1 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) begin
            load_valid_i = 1'b0;
            load_bit_i   = 1'($urandom);
            eval_valid_i = 1'b0;
            tick();
            check_eq("gap_f_hold", {f_valid_o, f_o}, {1'b0, exp_f});
            check_eq("gap_done", load_done_o, 0);
         end
      end
      load_valid_i = 1'b0; eval_valid_i = 1'b0; sweep_start_i = 1'b0;
      if (nbits == 16) model_active = tbl;
   endtask

   task automatic eval_at(input logic [3:0] xv);
      eval_valid_i = 1'b1;
      x_i = xv;
      tick();
      check_eq("eval_f", {f_valid_o, f_o}, {1'b1, model_active[xv]});
      check_eq("eval_no_pulse", {load_done_o, sweep_done_o}, 0);
      eval_valid_i = 1'b0;
      x_i = 4'($urandom);
      tick();
      check_eq("eval_hold", {f_valid_o, f_o}, {1'b0, model_active[xv]});
   endtask

   task automatic run_sweep();
      sweep_start_i = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         check_eq("sw_valid", sw_valid_o, 1);
         check_eq("sw_idx", sw_idx_o, i);
         check_eq("sw_f", sw_f_o, model_active[i]);
         check_eq("sw_last", sw_last_o, (i == 15));
         check_eq("sw_busy_ready", {busy_o, load_ready_o, sweep_done_o}, 32'b100);
         sweep_start_i = (i < 15) ? 1'($urandom) : 1'b0;
         load_valid_i  = (i < 15) ? 1'($urandom) : 1'b0;
         load_bit_i    = 1'($urandom);
         eval_valid_i  = 1'b1;
         x_i           = 4'($urandom);
         tick();
         check_eq("sw_eval_f", {f_valid_o, f_o}, {1'b1, model_active[x_i]});
      end
      eval_valid_i = 1'b0;
      check_eq("sw_done", {sw_valid_o, sweep_done_o, busy_o, load_ready_o}, 32'b0111);
      check_eq("ones_count", ones_count_o, 32'($countones(model_active)));
      tick();
      check_eq("sw_after", {sweep_done_o, busy_o, sw_valid_o}, 0);
      check_eq("ones_hold", ones_count_o, 32'($countones(model_active)));
   endtask

   initial begin
      logic [15:0] tbl;
      do_reset();
      eval_at(4'b1010);

      load_table(16'h6996, 1, 1'b0, 16);
      eval_at(4'b0111);
      eval_at(4'b1111);
      eval_at(4'b0001);
      run_sweep();

      // Commit-edge eval returns the old table; the next one sees the new table.
      load_table(16'hFFFF, 0, 1'b0, 16);
      eval_at(4'b0000);

      load_table(16'hFFFF, 0, 1'b0, 7);
      do_reset();
      eval_at(4'd3);
      load_table(16'h8000, 2, 1'b0, 16);
      eval_at(4'd15);
      run_sweep();

      // Load wins over a simultaneous sweep_start.
      load_table(16'h1234, 0, 1'b1, 16);
      check_eq("load_win_no_sweep", {busy_o, sw_valid_o}, 0);
      run_sweep();

      // Reset aborts a sweep without sweep_done.
      sweep_start_i = 1'b1;
      tick();
      sweep_start_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      do_reset();
      for (int i = 0; i < 18; i++) begin
         tick();
         check_eq("abort_no_done", {sweep_done_o, busy_o}, 0);
      end

      for (int r = 0; r < 8; r++) begin
         tbl = 16'($urandom);
         load_table(tbl, 2, 1'($urandom), 16);
         for (int k = 0; k < 4; k++) eval_at(4'($urandom));
         run_sweep();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/lut_func_eval.md
# lut_func_eval

Parametrised, reprogrammable N-input Boolean function unit for the combinational-logic lab datapath. It replaces fixed gate-level realisations of a single function with a 2^N-bit truth table. The table is loaded serially through a valid/ready handshake and committed atomically. The block evaluates the function on demand with a registered output, and can sweep all 2^N input combinations while counting minterms.

## Interface
- N, default 4: number of function inputs (legal range 2..8).
- INIT, default all zeros (2^N bits): active truth table after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_valid  in  1  serial table bit offered.
- load_bit  in  1  table bit; the first accepted bit is table[0].
- load_ready  out  1  high in IDLE and LOAD.
- load_done  out  1  one-cycle pulse after table commit.
- x  in  N  evaluation input; x[N-1] is the MSB of the table index.
- eval_valid  in  1  evaluate x this cycle.
- f  out  1  registered table[x].
- f_valid  out  1  registered eval_valid.
- sweep_start  in  1  request full-table sweep.
- busy  out  1  sweep in progress.
- sw_idx  out  N  current sweep index.
- sw_f  out  1  table[sw_idx].
- sw_valid  out  1  sw_idx/sw_f valid.
- sw_last  out  1  marks sw_idx = 2^N-1.
- ones_count  out  N+1  number of 1-minterms in the table.
- sweep_done  out  1  one-cycle pulse; ones_count final.

## Operation
- FSM states: IDLE, LOAD, SWEEP.
- Two table registers: active and shadow. Evaluation and sweep always read active.
- IDLE:
  - load_valid → LOAD; the bit offered this cycle is accepted as bit 0.
  - Otherwise sweep_start → SWEEP.
  - If both are asserted, load wins and sweep_start is dropped.
- LOAD:
  - Each edge with load_valid&&load_ready writes shadow[cnt] and increments cnt; gaps in load_valid are allowed.
  - On the 2^N-th accept: active ← shadow in the same edge, cnt ← 0, state → IDLE, load_done pulses.
  - sweep_start is ignored in LOAD.
- SWEEP:
  - idx runs 0..2^N-1, one per cycle.
  - ones_count is cleared at entry and accumulates table[idx].
  - After idx 2^N-1 the FSM returns to IDLE and sweep_done pulses.
  - load_ready is low in SWEEP; sweep_start while busy is ignored.
- Eval path is independent of the FSM and valid in every state.
- Eval edge behaviour: f ← active[x], f_valid ← eval_valid. When eval and commit share an edge, f returns the pre-commit table.
- f holds its value when eval_valid is low.
- ones_count holds between sweeps and is not updated by loads.
- Reset:
  - All outputs 0; state IDLE; active ← INIT; shadow and cnt cleared.
  - A partial load is discarded and a new load needs the full 2^N bits.
  - A sweep in progress is aborted with no sweep_done.

## Timing
- Eval latency: 1 cycle (x sampled at edge k, f/f_valid visible after edge k).
- Load: load_done is high in the cycle after the final accepting edge. Minimum load time is 2^N cycles; load_ready stays high throughout LOAD.
- Sweep, with sweep_start sampled at edge t:
  - sw_valid is high for cycles t+1 .. t+2^N with sw_idx = 0..2^N-1.
  - sw_last is high in cycle t+2^N.
  - sweep_done and the final ones_count appear in cycle t+2^N+1.
  - busy is high for cycles t+1 .. t+2^N+1; a new sweep_start is accepted at the first edge after that.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, N=4, INIT=0: after rst_n low for 1 cycle, every output is 0. eval x=4'b1010 gives f=0 and f_valid=1 one cycle later.
- Load odd-parity table 16'h6996 (LSB first, load_valid toggling every other cycle): load_done pulses once after the 16th accept. Then eval x=4'b0111 → f=1, x=4'b1111 → f=0, x=4'b0001 → f=1.
- Sweep on 16'h6996: 16 consecutive sw_valid cycles with sw_f = bits of 16'h6996 in index order, and sw_last at idx 15. sweep_done arrives in the 17th cycle after start with ones_count=8; busy is high for 17 cycles.
- Eval during load: with active=16'h6996 and a load of 16'hFFFF in progress, x=0 returns 0 through bit 15. x=0 sampled on the commit edge also returns 0; the next eval returns 1.
- Reset mid-load after 7 bits of 16'hFFFF: active=INIT (x=3 → f=0). A following 16-bit load of 16'h8000 commits correctly, and x=15 → f=1.
- sweep_start together with load_valid in IDLE: load proceeds and no sw_valid appears. sweep_start asserted during SWEEP: no restart, and ones_count is still final in the 17th cycle.
